// File: rtl/wb_queue.sv
// Writeback queue: buffers register writes from multi-cycle units and drains
// them into the regfile write port on cycles the main pipeline leaves idle.
module wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_reg,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     wb_busy,
  output logic                     ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0]    ctrl_writeReg,
  output logic [DATA_WIDTH-1:0]    data_writeReg,
  input  logic [ADDR_WIDTH-1:0]    query_reg,
  output logic                     query_hit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_count;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH-1:0]      w_valid_next;
  logic                  w_hit;

  assign in_ready = (r_count < FULL_COUNT);
  assign empty    = (r_count == '0);
  assign count    = r_count;

  // Register 0 completes the handshake but is never stored.
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && (in_reg != '0);
  assign w_pop    = !empty && !wb_busy;

  assign ctrl_writeEnable = w_pop;
  assign ctrl_writeReg    = w_pop ? r_reg[r_head]  : '0;
  assign data_writeReg    = w_pop ? r_data[r_head] : '0;

  always_comb begin
    w_valid_next = r_valid;
    if (w_pop) begin
      w_valid_next[r_head] = 1'b0;
    end else begin
      w_valid_next = w_valid_next;
    end
    if (w_push) begin
      w_valid_next[r_tail] = 1'b1;
    end else begin
      w_valid_next = w_valid_next;
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit = w_hit | (r_valid[i] && (r_reg[i] == query_reg));
    end
    query_hit = w_hit && (query_reg != '0);
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_next;
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is never read without its valid bit, so it needs no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_reg[r_tail]  <= in_reg;
      r_data[r_tail] <= in_data;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed vector bench for wb_queue: per-cycle table plus an async reset sequence.
module tb_wb_queue;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        wb_busy;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  query_reg;
  logic        query_hit;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
    logic        busy;
    logic [4:0]  q;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [2:0]  cnt;
    logic        rdy;
    logic        hit;
  } vec_t;

  vec_t vq[$];

  wb_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wb_busy(wb_busy), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .query_reg(query_reg), .query_hit(query_hit), .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [4:0] r, input logic [31:0] d,
                     input logic busy, input logic [4:0] q, input logic we,
                     input logic [4:0] wr, input logic [31:0] wd,
                     input logic [2:0] cnt, input logic rdy, input logic hit);
    vec_t t;
    t.v = v; t.r = r; t.d = d; t.busy = busy; t.q = q;
    t.we = we; t.wr = wr; t.wd = wd; t.cnt = cnt; t.rdy = rdy; t.hit = hit;
    vq.push_back(t);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_hit"},   32'(query_hit), 32'd0);
    check({tag, "_we"},    32'(ctrl_writeEnable), 32'd0);
    check({tag, "_wreg"},  32'(ctrl_writeReg), 32'd0);
    check({tag, "_wdata"}, data_writeReg, 32'd0);
  endtask

  initial begin
    //   v     reg     data          busy  q      we    wr     wd            cnt   rdy   hit
    // single write
    add(1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  1'b1, 5'd7,  32'hDEADBEEF, 3'd1, 1'b1, 1'b1);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);
    // fill while busy, fifth push ignored, then drain in order
    add(1'b1, 5'd1,  32'h11,       1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);
    add(1'b1, 5'd2,  32'h22,       1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd1, 1'b1, 1'b0);
    add(1'b1, 5'd3,  32'h33,       1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd2, 1'b1, 1'b0);
    add(1'b1, 5'd4,  32'h44,       1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd3, 1'b1, 1'b0);
    add(1'b1, 5'd5,  32'h55,       1'b1, 5'd5,  1'b0, 5'd0,  32'h0,        3'd4, 1'b0, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  1'b1, 5'd1,  32'h11,       3'd4, 1'b0, 1'b1);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b1, 5'd2,  32'h22,       3'd3, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b1, 5'd3,  32'h33,       3'd2, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b1, 5'd4,  32'h44,       3'd1, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);
    // full with push pending, then push+pop together, ten entries wrapping
    add(1'b1, 5'd10, 32'h100,      1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);
    add(1'b1, 5'd11, 32'h101,      1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd1, 1'b1, 1'b0);
    add(1'b1, 5'd12, 32'h102,      1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd2, 1'b1, 1'b0);
    add(1'b1, 5'd13, 32'h103,      1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd3, 1'b1, 1'b0);
    add(1'b1, 5'd14, 32'h104,      1'b0, 5'd0,  1'b1, 5'd10, 32'h100,      3'd4, 1'b0, 1'b0);
    add(1'b1, 5'd14, 32'h104,      1'b0, 5'd0,  1'b1, 5'd11, 32'h101,      3'd3, 1'b1, 1'b0);
    add(1'b1, 5'd15, 32'h105,      1'b0, 5'd0,  1'b1, 5'd12, 32'h102,      3'd3, 1'b1, 1'b0);
    add(1'b1, 5'd16, 32'h106,      1'b0, 5'd0,  1'b1, 5'd13, 32'h103,      3'd3, 1'b1, 1'b0);
    add(1'b1, 5'd17, 32'h107,      1'b0, 5'd0,  1'b1, 5'd14, 32'h104,      3'd3, 1'b1, 1'b0);
    add(1'b1, 5'd18, 32'h108,      1'b0, 5'd0,  1'b1, 5'd15, 32'h105,      3'd3, 1'b1, 1'b0);
    add(1'b1, 5'd19, 32'h109,      1'b0, 5'd0,  1'b1, 5'd16, 32'h106,      3'd3, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd17, 32'h107,      3'd3, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd18, 32'h108,      3'd2, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd19, 32'h109,      3'd1, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);
    // register 0 discarded, query behaviour
    add(1'b1, 5'd0,  32'd99,       1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);
    add(1'b1, 5'd9,  32'd5,        1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        3'd1, 1'b1, 1'b1);
    add(1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd1, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        3'd1, 1'b1, 1'b0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  1'b1, 5'd9,  32'd5,        3'd1, 1'b1, 1'b1);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);
    // same-register ordering
    add(1'b1, 5'd12, 32'hA,        1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);
    add(1'b1, 5'd12, 32'hB,        1'b1, 5'd12, 1'b0, 5'd0,  32'h0,        3'd1, 1'b1, 1'b1);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd12, 1'b1, 5'd12, 32'hA,        3'd2, 1'b1, 1'b1);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd12, 1'b1, 5'd12, 32'hB,        3'd1, 1'b1, 1'b1);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd12, 1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0);

    ctrl_reset = 1'b0;
    in_valid   = 1'b0;
    in_reg     = 5'd0;
    in_data    = 32'h0;
    wb_busy    = 1'b0;
    query_reg  = 5'd0;
    #1;
    check_reset_outputs("init");
    @(negedge clock);
    ctrl_reset = 1'b1;

    foreach (vq[i]) begin
      in_valid  = vq[i].v;
      in_reg    = vq[i].r;
      in_data   = vq[i].d;
      wb_busy   = vq[i].busy;
      query_reg = vq[i].q;
      #1;
      check($sformatf("v%0d_we", i),    32'(ctrl_writeEnable), 32'(vq[i].we));
      check($sformatf("v%0d_wreg", i),  32'(ctrl_writeReg),    32'(vq[i].wr));
      check($sformatf("v%0d_wdata", i), data_writeReg,         vq[i].wd);
      check($sformatf("v%0d_count", i), 32'(count),            32'(vq[i].cnt));
      check($sformatf("v%0d_empty", i), 32'(empty),            32'(vq[i].cnt == 3'd0));
      check($sformatf("v%0d_ready", i), 32'(in_ready),         32'(vq[i].rdy));
      check($sformatf("v%0d_hit", i),   32'(query_hit),        32'(vq[i].hit));
      @(negedge clock);
    end

    // Reset mid-drain: three entries queued, first one strobing, then async reset.
    in_valid = 1'b1;
    wb_busy  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_reg  = 5'(20 + k);
      in_data = 32'(32'h200 + k);
      @(negedge clock);
    end
    in_valid  = 1'b0;
    wb_busy   = 1'b0;
    query_reg = 5'd21;
    #1;
    check("mid_we",    32'(ctrl_writeEnable), 32'd1);
    check("mid_wreg",  32'(ctrl_writeReg),    32'd20);
    check("mid_count", 32'(count),            32'd3);
    check("mid_hit",   32'(query_hit),        32'd1);
    #2;
    ctrl_reset = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge clock);
    check_reset_outputs("arst_hold");
    ctrl_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      check($sformatf("post_we%0d", k),    32'(ctrl_writeEnable), 32'd0);
      check($sformatf("post_count%0d", k), 32'(count),            32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
